alu_cntrl_vec_recorder: RTL and testbench

Synthesizable golden-vector recorder for the ALU control path. It samples `{opCode, funct, aluOp, invA, invB, Cin, sign}` tuples from a live `alu_cntrl` instance into a 14-bit-wide buffer, then streams them back out in capture order over a valid/ready port. It produces the 14-bit stimulus/response words the ALU control bench consumes, so it is the writer side of the `alu_cntrl_stim.bin` vector format. It sits beside `alu_cntrl` in the demo1 datapath and is driven by a host or debug sequencer.

---
 rtl/alu_cntrl_vec_recorder.sv | 120 ++++++++++++
 tb/tb_alu_cntrl_vec_recorder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cntrl_vec_recorder.sv
// Golden-vector recorder for the ALU control path: captures packed control tuples
// into a small register array, then replays them in capture order over valid/ready.
module alu_cntrl_vec_recorder #(
    parameter int DEPTH = 39,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    input  logic [4:0]    in_opCode,
    input  logic [1:0]    in_funct,
    input  logic [2:0]    in_aluOp,
    input  logic          in_invA,
    input  logic          in_invB,
    input  logic          in_Cin,
    input  logic          in_sign,
    output logic          in_ready,
    output logic          out_valid,
    output logic [13:0]   out_vec,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, REC, DUMP, DONE} state_e;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [13:0]   mem [DEPTH];
    logic [13:0]   in_word;
    logic [CW-1:0] rd_idx;
    logic          wr_en;
    logic          xfer;

    assign in_word = {in_opCode, in_funct, in_aluOp, in_invA, in_invB, in_Cin, in_sign};

    // start outranks every other request, so it also suppresses writes and transfers.
    assign wr_en = in_valid & in_ready & ~start;
    assign xfer  = out_valid & out_ready & ~start;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (start) begin
            state_d  = REC;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                REC: begin
                    if (wr_en) begin
                        wr_ptr_d = wr_ptr_q + ONE;
                        count_d  = count_q + ONE;
                    end
                    if (wr_en && (count_q + ONE == DEPTH_C)) begin
                        state_d = DUMP;
                    end else if (stop) begin
                        state_d = (wr_en || count_q != '0) ? DUMP : DONE;
                    end
                end
                DUMP: begin
                    if (xfer) begin
                        rd_ptr_d = rd_ptr_q + ONE;
                        if (rd_ptr_q + ONE == count_q) state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            REC:     in_ready  = (count_q < DEPTH_C);
            DUMP:    out_valid = (rd_ptr_q < count_q);
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the vector array is deliberately not reset; count bounds which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_word;
    end

    // rd_ptr reaches DEPTH after a full dump; clamp so the read never leaves the array.
    assign rd_idx  = (rd_ptr_q < DEPTH_C) ? rd_ptr_q : '0;
    assign out_vec = mem[rd_idx];
    assign count   = count_q;

endmodule

// File: tb/tb_alu_cntrl_vec_recorder.sv
// Directed bench for alu_cntrl_vec_recorder: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge that consumed them.
module tb_alu_cntrl_vec_recorder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, in_valid, out_ready;
    logic [4:0]  in_opCode;
    logic [1:0]  in_funct;
    logic [2:0]  in_aluOp;
    logic        in_invA, in_invB, in_Cin, in_sign;
    logic        in_ready, out_valid, done;
    logic [13:0] out_vec;
    logic [5:0]  count;

    int n_vec = 0;
    int n_err = 0;

    alu_cntrl_vec_recorder #(.DEPTH(39), .CW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .in_opCode(in_opCode), .in_funct(in_funct), .in_aluOp(in_aluOp),
        .in_invA(in_invA), .in_invB(in_invB), .in_Cin(in_Cin), .in_sign(in_sign),
        .in_ready(in_ready), .out_valid(out_valid), .out_vec(out_vec),
        .out_ready(out_ready), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic set_word(input logic [13:0] w);
        {in_opCode, in_funct, in_aluOp, in_invA, in_invB, in_Cin, in_sign} = w;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic write(input logic [13:0] w);
        set_word(w);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] rec3 [3];
        rec3[0] = 14'h0001; rec3[1] = 14'h1ABC; rec3[2] = 14'h3FFF;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_word(14'h0);
        cycle(); cycle();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Record three words, stop, then dump with a four-cycle stall on word 2.
        pulse_start();
        check("rec_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) write(rec3[i]);
        check("rec3_count", 32'(count), 32'd3);
        pulse_stop();
        check("dump_in_ready", 32'(in_ready), 32'd0);
        check("dump_valid0", 32'(out_valid), 32'd1);
        check("dump_word0", 32'(out_vec), 32'h0001);
        out_ready = 1'b1;
        cycle();
        check("dump_word1", 32'(out_vec), 32'h1ABC);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_word", 32'(out_vec), 32'h1ABC);
        end
        out_ready = 1'b1;
        cycle();
        check("dump_valid2", 32'(out_valid), 32'd1);
        check("dump_word2", 32'(out_vec), 32'h3FFF);
        cycle();
        out_ready = 1'b0;
        check("rec3_done", 32'(done), 32'd1);
        check("rec3_out_valid_off", 32'(out_valid), 32'd0);
        check("rec3_count_hold", 32'(count), 32'd3);

        // Fill all 39 entries, offer a 40th, then dump everything.
        pulse_start();
        check("fill_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 39; i++) begin
            check("fill_in_ready", 32'(in_ready), 32'd1);
            write(14'(i));
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd39);
        write(14'h155);
        check("over_count", 32'(count), 32'd39);
        for (int i = 0; i < 39; i++) begin
            check("fill_valid", 32'(out_valid), 32'd1);
            check("fill_word", 32'(out_vec), 32'(i));
            out_ready = 1'b1;
            cycle();
        end
        out_ready = 1'b0;
        check("fill_done", 32'(done), 32'd1);
        check("fill_out_valid_off", 32'(out_valid), 32'd0);
        check("fill_count", 32'(count), 32'd39);

        // Stop on an empty buffer goes straight to DONE.
        pulse_start();
        pulse_stop();
        check("empty_done", 32'(done), 32'd1);
        check("empty_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("empty_out_valid", 32'(out_valid), 32'd0);
            cycle();
        end

        // Restart while word 1 of 3 is pending; start beats out_ready.
        pulse_start();
        write(14'h00A5); write(14'h0111); write(14'h0222);
        pulse_stop();
        out_ready = 1'b1;
        cycle();
        check("restart_pending", 32'(out_vec), 32'h0111);
        pulse_start();
        out_ready = 1'b0;
        check("restart_in_ready", 32'(in_ready), 32'd1);
        check("restart_count", 32'(count), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_out_valid", 32'(out_valid), 32'd0);
        // Write and stop in the same cycle on an empty buffer: the word is kept.
        set_word(14'h2C3);
        in_valid = 1'b1; stop = 1'b1;
        cycle();
        in_valid = 1'b0; stop = 1'b0;
        check("one_count", 32'(count), 32'd1);
        check("one_valid", 32'(out_valid), 32'd1);
        check("one_word", 32'(out_vec), 32'h02C3);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("one_done", 32'(done), 32'd1);
        check("one_out_valid_off", 32'(out_valid), 32'd0);

        // Asynchronous reset between clock edges after two writes.
        pulse_start();
        write(14'h0011); write(14'h0022);
        check("pre_rst_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        pulse_stop();
        check("idle_stop_valid", 32'(out_valid), 32'd0);
        check("idle_stop_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
